stitch_pipeline_out_buffer: RTL and testbench

//   Downstream companion of a stitched, stall-free DSLX pipeline (clk only, no valid, no reset).
//   - Tracks a valid bit alongside the pipeline's fixed latency.
//   - Captures each valid pipeline result into a small FIFO.
//   - Presents the results on a ready/valid output port.
//   - Limits upstream issue with credits, so no result is ever dropped when the consumer stalls.

---
 rtl/stitch_pipeline_out_buffer.sv | 93 +++++++++
 tb/tb_stitch_pipeline_out_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stitch_pipeline_out_buffer.sv
// Output buffer for a stall-free stitched pipeline: valid tracking, credit-limited issue and a result FIFO.
// Optional STITCH_OUT_BUF_BYPASS_EN: an empty FIFO forwards pipe_out to out_data in the same cycle.
module stitch_pipeline_out_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] pipe_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [LATENCY-1:0]    vld;
    logic [CNT_W-1:0]      inflight_cnt;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [CNT_W-1:0]      occ;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  accept;
    logic                  push;
    logic                  write;
    logic                  pop;
    logic                  fifo_nonempty;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // depends on ready, and in_ready depends only on registered counts (plus rst).
    assign occ           = inflight_cnt + fifo_cnt;
    assign in_ready      = !rst && (occ < FULL_CNT);
    assign accept        = in_valid && in_ready;
    assign push          = vld[LATENCY-1];
    assign fifo_nonempty = (fifo_cnt != '0);
    assign pop           = !rst && fifo_nonempty && out_ready;

`ifdef STITCH_OUT_BUF_BYPASS_EN
    // A result landing on an empty FIFO with the consumer ready is handed over directly.
    assign write     = push && !(!fifo_nonempty && out_ready);
    assign out_valid = !rst && (fifo_nonempty || push);
    assign out_data  = fifo_nonempty ? mem[rd_ptr] : pipe_out;
`else
    assign write     = push;
    assign out_valid = !rst && fifo_nonempty;
    assign out_data  = mem[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld          <= '0;
            inflight_cnt <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            vld <= LATENCY'({vld, accept});
            case ({accept, push})
                2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
            case ({write, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (write) wr_ptr <= next_ptr(wr_ptr);
            if (pop)   rd_ptr <= next_ptr(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (write) mem[wr_ptr] <= pipe_out;
    end

`ifndef SYNTHESIS
    // Credits bound occupancy, so a write into a full FIFO without a matching pop is a bug.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(write && !pop && (fifo_cnt == FULL_CNT)));
    end
`endif
endmodule

// File: tb/tb_stitch_pipeline_out_buffer.sv
// Directed and random bench for stitch_pipeline_out_buffer with a two-stage identity pipeline model.
module tb_stitch_pipeline_out_buffer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] pipe_out;
    logic [W-1:0] out_data;
    logic [W-1:0] p1;
    logic [W-1:0] p2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    // Monitor state
    logic [1:0]   acc_sr = 2'b00;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         accept_now;
    logic         pop_now;
    logic         push_now;
    logic [W-1:0] exp_val;
    int pop_cnt = 0;
    int first_pop = -1;
    int last_pop = -1;
    int full_pp = 0;
    int empty_push = 0;

    int n_acc;
    int stalls;
    int wait_cnt;

    stitch_pipeline_out_buffer #(
        .DATA_WIDTH(32),
        .LATENCY   (2),
        .DEPTH     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pipe_out (pipe_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    // Clock and the stall-free pipeline being buffered
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        p1  <= in_data;
        p2  <= p1;
    end
    assign pipe_out = p2;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepts push the driven data, pops compare against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_sr     = 2'b00;
            prev_stall = 1'b0;
        end else begin
            accept_now = in_valid && in_ready;
            pop_now    = out_valid && out_ready;
            push_now   = acc_sr[1];
            if (prev_stall) begin
                check("hold_valid", W'(out_valid), W'(1));
                check("hold_data", out_data, prev_data);
            end
            if (push_now && !out_valid) empty_push++;
            if (push_now && pop_now && !in_ready) full_pp++;
            if (accept_now) exp_q.push_back(in_data);
            if (pop_now) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_output: observed %0h expected no output", out_data);
                end
                if (exp_q.size() != 0) begin
                    exp_val = exp_q.pop_front();
                    check("sb_data", out_data, exp_val);
                end
                pop_cnt++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            acc_sr     = {acc_sr[0], accept_now};
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = '0;

        // Reset held with in_valid asserted
        repeat (3) begin
            step();
            check("rst_in_ready", W'(in_ready), W'(0));
            check("rst_out_valid", W'(out_valid), W'(0));
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rel_in_ready", W'(in_ready), W'(1));

        // Single token: out_valid three cycles after the accept cycle
        out_ready = 1'b1;
        in_data   = 32'h0000_0007;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = $urandom;
        check("t2_lat1_valid", W'(out_valid), W'(0));
        step();
        check("t2_lat2_valid", W'(out_valid), W'(0));
        step();
        check("t2_lat3_valid", W'(out_valid), W'(1));
        check("t2_data", out_data, 32'h0000_0007);
        step();
        check("t2_after_valid", W'(out_valid), W'(0));

        // Backpressure: credits stop issue at DEPTH
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n_acc     = 0;
        repeat (10) begin
            in_data = $urandom;
            if (in_ready) n_acc++;
            step();
        end
        check("t3_accepts", W'(n_acc), W'(4));
        check("t3_in_ready_low", W'(in_ready), W'(0));
        check("t3_out_valid", W'(out_valid), W'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t3_credit_before_pop", W'(in_ready), W'(0));
        step();
        check("t3_credit_after_pop", W'(in_ready), W'(1));
        repeat (4) step();
        check("t3_drained", W'(out_valid), W'(0));
        check("t3_sb_empty", W'(exp_q.size()), W'(0));

        // Streaming 0..99 with the consumer always ready
        out_ready = 1'b1;
        stalls    = 0;
        pop_cnt   = 0;
        first_pop = -1;
        last_pop  = -1;
        for (int i = 0; i < 100; i++) begin
            in_data  = W'(i);
            in_valid = 1'b1;
            wait_cnt = 0;
            while (!in_ready && wait_cnt < 50) begin
                step();
                wait_cnt++;
                stalls++;
            end
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        check("t4_stalls", W'(stalls), W'(0));
        check("t4_count", W'(pop_cnt), W'(100));
        check("t4_span", W'(last_pop - first_pop), W'(99));

        // Random traffic on both sides
        for (int i = 0; i < 2000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        check("t5_sb_empty", W'(exp_q.size()), W'(0));
        check("t5_full_push_pop", W'(full_pp >= 10), W'(1));
        check("t5_empty_push", W'(empty_push >= 10), W'(1));

        // Reset with two results buffered and two in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (4) begin
            in_data = $urandom;
            step();
        end
        in_valid = 1'b0;
        check("t6_pre_rst_valid", W'(out_valid), W'(1));
        rst = 1'b1;
        step();
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            step();
            check("t6_quiet", W'(out_valid), W'(0));
        end
        in_data  = 32'hCAFE_F00D;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = $urandom;
        step();
        step();
        check("t6_token_valid", W'(out_valid), W'(1));
        check("t6_token_data", out_data, 32'hCAFE_F00D);
        repeat (3) step();
        check("t6_sb_empty", W'(exp_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
